muller_c_hs_driver: RTL

Synchronous four-phase handshake sequencer that drives both inputs of the Muller C-element and consumes its asynchronous output. It raises and lowers the two C-element inputs with a programmable skew and waits for the output to follow. It also counts completed handshakes and flags timeouts or premature output transitions. It sits between the user-project I/O control logic and the C-element core, and is the on-chip stimulus/checker for that core.

---
 rtl/muller_c_hs_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/muller_c_hs_driver.sv
// Four-phase handshake sequencer for a Muller C-element.
// Drives both inputs with programmable skew and checks the output.
module muller_c_hs_driver #(
  parameter int CNT_W  = 16,
  parameter int SKEW_W = 4,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic              a_first,
  input  logic [SKEW_W-1:0] skew,
  input  logic              clr_err,
  input  logic              c_y,
  output logic              c_a,
  output logic              c_b,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE,
    RISE_SKEW,
    RISE_WAIT,
    FALL_SKEW,
    FALL_WAIT,
    ERROR
  } state_t;

  state_t              state;
  logic                y_m;
  logic                y_s;
  logic                fst;
  logic                snd;
  logic                a_first_q;
  logic                cont_q;
  logic                stop_pending;
  logic [SKEW_W-1:0]   skew_q;
  logic [SKEW_W-1:0]   skew_cnt;
  logic [TMO_W-1:0]    tmo;
  logic [SKEW_W-1:0]   sk_src;
  logic                launch;
  logic                prem;
  logic                tout;

  assign c_a = a_first_q ? fst : snd;
  assign c_b = a_first_q ? snd : fst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_m <= 1'b0;
      y_s <= 1'b0;
    end else begin
      y_m <= c_y;
      y_s <= y_m;
    end
  end

  // A new rise starts from IDLE or straight out of a completed fall.
  assign launch =
    (state == IDLE && start) ||
    (state == FALL_WAIT && !y_s && cont_q &&
     !stop_pending && !stop);

  assign sk_src = (state == IDLE) ? skew : skew_q;

  assign prem =
    (state == RISE_SKEW && y_s) ||
    (state == FALL_SKEW && !y_s);

  assign tout = (&tmo) && (
    (state == RISE_WAIT && !y_s) ||
    (state == FALL_WAIT && y_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fst          <= 1'b0;
      snd          <= 1'b0;
      a_first_q    <= 1'b0;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
      skew_q       <= '0;
      skew_cnt     <= '0;
      tmo          <= '0;
      busy         <= 1'b0;
      done_cnt     <= '0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      if (stop && busy)
        stop_pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            skew_q    <= skew;
            a_first_q <= a_first;
            cont_q    <= cont;
            busy      <= 1'b1;
          end
        end
        RISE_SKEW: begin
          skew_cnt <= skew_cnt - 1'b1;
          if (skew_cnt == 1) begin
            snd   <= 1'b1;
            tmo   <= '0;
            state <= RISE_WAIT;
          end
        end
        RISE_WAIT: begin
          if (y_s) begin
            fst      <= 1'b0;
            skew_cnt <= skew_q;
            if (skew_q == 0) begin
              snd   <= 1'b0;
              tmo   <= '0;
              state <= FALL_WAIT;
            end else begin
              state <= FALL_SKEW;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FALL_SKEW: begin
          skew_cnt <= skew_cnt - 1'b1;
          if (skew_cnt == 1) begin
            snd   <= 1'b0;
            tmo   <= '0;
            state <= FALL_WAIT;
          end
        end
        FALL_WAIT: begin
          if (!y_s) begin
            done_cnt     <= done_cnt + 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ERROR: begin
          if (clr_err) begin
            state    <= IDLE;
            err      <= 1'b0;
            err_code <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase

      if (launch) begin
        fst      <= 1'b1;
        skew_cnt <= sk_src;
        tmo      <= '0;
        busy     <= 1'b1;
        if (sk_src == 0) begin
          snd   <= 1'b1;
          state <= RISE_WAIT;
        end else begin
          state <= RISE_SKEW;
        end
      end

      if (prem || tout) begin
        state    <= ERROR;
        fst      <= 1'b0;
        snd      <= 1'b0;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= prem ? 2'b10 : 2'b01;
      end
    end
  end

endmodule
